// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared widths, job/result records and FSM states for the GCD requester
package gcd_pkg;

   localparam int GCD_WIDTH = 32;
   localparam int GCD_TAG_W = 4;
   localparam int GCD_CYC_W = 16;

   typedef struct packed {
      logic [GCD_WIDTH-1:0] va;
      logic [GCD_WIDTH-1:0] vb;
      logic [GCD_TAG_W-1:0] tag;
   } job_t;

   typedef struct packed {
      logic [GCD_WIDTH-1:0] v;
      logic [GCD_TAG_W-1:0] tag;
      logic [GCD_CYC_W-1:0] cycles;
   } result_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } req_state_e;

endpackage

// File: rtl/gcd_requester_if.sv
// rtl/gcd_requester_if.sv - job, result, request and indication ENA/RDY channels of the GCD requester
interface gcd_requester_if
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int TAG_W = GCD_TAG_W,
   parameter int CYC_W = GCD_CYC_W
);
   logic             job_enq_ena;
   logic [WIDTH-1:0] job_enq_va;
   logic [WIDTH-1:0] job_enq_vb;
   logic [TAG_W-1:0] job_enq_tag;
   logic             job_enq_rdy;

   logic             result_deq_ena;
   logic [WIDTH-1:0] result_deq_v;
   logic [TAG_W-1:0] result_deq_tag;
   logic [CYC_W-1:0] result_deq_cycles;
   logic             result_deq_rdy;

   logic             request_say_ena;
   logic [WIDTH-1:0] request_say_va;
   logic [WIDTH-1:0] request_say_vb;
   logic             request_say_rdy;

   logic             indication_gcd_ena;
   logic [WIDTH-1:0] indication_gcd_v;
   logic             indication_gcd_rdy;

   // master: the requester itself; slave: upstream, downstream and engine around it
   modport master (
      input  job_enq_ena, job_enq_va, job_enq_vb, job_enq_tag,
      output job_enq_rdy,
      output result_deq_ena, result_deq_v, result_deq_tag, result_deq_cycles,
      input  result_deq_rdy,
      output request_say_ena, request_say_va, request_say_vb,
      input  request_say_rdy,
      input  indication_gcd_ena, indication_gcd_v,
      output indication_gcd_rdy
   );

   modport slave (
      output job_enq_ena, job_enq_va, job_enq_vb, job_enq_tag,
      input  job_enq_rdy,
      input  result_deq_ena, result_deq_v, result_deq_tag, result_deq_cycles,
      output result_deq_rdy,
      input  request_say_ena, request_say_va, request_say_vb,
      output request_say_rdy,
      output indication_gcd_ena, indication_gcd_v,
      input  indication_gcd_rdy
   );

endinterface

// File: rtl/gcd_job_fifo.sv
// rtl/gcd_job_fifo.sv - DEPTH-entry FIFO of job records with ENA/RDY on both sides, no bypass
module gcd_job_fifo
   import gcd_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = job_t
) (
   input  logic CLK,
   input  logic nRST,
   input  logic enq_ena_i,
   input  T     enq_data_i,
   output logic enq_rdy_o,
   input  logic deq_ena_i,
   output T     deq_data_o,
   output logic deq_rdy_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   T                 mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             do_enq;
   logic             do_deq;

   // Ready is forced low while in reset so upstream never sees a spurious slot.
   assign enq_rdy_o  = nRST && (count_q != CNT_W'(DEPTH));
   assign deq_rdy_o  = (count_q != '0);
   assign do_enq     = enq_ena_i && enq_rdy_o;
   assign do_deq     = deq_ena_i && deq_rdy_o;
   assign deq_data_o = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({do_enq, do_deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_enq) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_deq) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_enq) mem_q[wr_ptr_q] <= enq_data_i;
   end

endmodule

// File: rtl/gcd_requester.sv
// rtl/gcd_requester.sv - queues tagged operand pairs, issues them one at a time to the GCD engine, returns {gcd, tag, latency}
module gcd_requester
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int TAG_W = GCD_TAG_W,
   parameter int DEPTH = 2,
   parameter int CYC_W = GCD_CYC_W
) (
   input  logic            CLK,
   input  logic            nRST,
   gcd_requester_if.master bus,
   output logic            busy
);
   typedef struct packed {
      logic [WIDTH-1:0] va;
      logic [WIDTH-1:0] vb;
      logic [TAG_W-1:0] tag;
   } job_w_t;

   typedef struct packed {
      logic [WIDTH-1:0] v;
      logic [TAG_W-1:0] tag;
      logic [CYC_W-1:0] cycles;
   } res_w_t;

   req_state_e       state_q, state_d;
   job_w_t           cur_q, cur_d;
   res_w_t           res_q, res_d;
   logic             res_valid_q, res_valid_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   job_w_t           enq_job;
   job_w_t           head;
   logic             head_valid;
   logic             pop;
   logic             start;
   logic             zero_pair;
   logic             say_ena;
   logic             ind_rdy;

   assign enq_job = '{va: bus.job_enq_va, vb: bus.job_enq_vb, tag: bus.job_enq_tag};

   gcd_job_fifo #(
      .DEPTH (DEPTH),
      .T     (job_w_t)
   ) u_fifo (
      .CLK        (CLK),
      .nRST       (nRST),
      .enq_ena_i  (bus.job_enq_ena),
      .enq_data_i (enq_job),
      .enq_rdy_o  (bus.job_enq_rdy),
      .deq_ena_i  (pop),
      .deq_data_o (head),
      .deq_rdy_o  (head_valid)
   );

   // A new job starts only into an empty result slot, so load and drain never collide.
   assign start     = (state_q == IDLE) && head_valid && !res_valid_q;
   assign zero_pair = (head.va == '0) && (head.vb == '0);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         cyc_q       <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         cyc_q       <= cyc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start && !zero_pair) state_d = ISSUE;
         ISSUE:   if (bus.request_say_rdy) state_d = WAIT;
         WAIT:    if (bus.indication_gcd_ena) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop         = 1'b0;
      say_ena     = 1'b0;
      ind_rdy     = 1'b0;
      cur_d       = cur_q;
      res_d       = res_q;
      res_valid_d = res_valid_q && !bus.result_deq_rdy;
      cyc_d       = cyc_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               pop = 1'b1;
               // The engine never answers (0,0), so that result is produced here.
               if (zero_pair) begin
                  res_d       = '{v: '0, tag: head.tag, cycles: '0};
                  res_valid_d = 1'b1;
               end else begin
                  cur_d = head;
               end
            end
         end
         ISSUE: begin
            say_ena = 1'b1;
            if (bus.request_say_rdy) cyc_d = '0;
         end
         WAIT: begin
            ind_rdy = 1'b1;
            cyc_d   = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
            if (bus.indication_gcd_ena) begin
               res_d       = '{v: bus.indication_gcd_v, tag: cur_q.tag, cycles: cyc_q};
               res_valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.request_say_ena    = say_ena;
   assign bus.request_say_va     = cur_q.va;
   assign bus.request_say_vb     = cur_q.vb;
   assign bus.indication_gcd_rdy = ind_rdy;
   assign bus.result_deq_ena     = res_valid_q;
   assign bus.result_deq_v       = res_q.v;
   assign bus.result_deq_tag     = res_q.tag;
   assign bus.result_deq_cycles  = res_q.cycles;
   assign busy                   = head_valid || (state_q != IDLE) || res_valid_q;

endmodule

// File: tb/tb_gcd_requester.sv
// tb/tb_gcd_requester.sv - self-checking bench for gcd_requester with a behavioural GCD engine
module tb_gcd_requester;
   import gcd_pkg::*;

   localparam int W  = GCD_WIDTH;
   localparam int TW = GCD_TAG_W;
   localparam int CW = GCD_CYC_W;

   typedef struct {
      logic [W-1:0]  va;
      logic [W-1:0]  vb;
      logic [TW-1:0] tag;
   } job_s;

   logic CLK = 1'b0;
   logic nRST;
   logic busy;

   gcd_requester_if #(.WIDTH(W), .TAG_W(TW), .CYC_W(CW)) bus ();

   gcd_requester #(.WIDTH(W), .TAG_W(TW), .DEPTH(2), .CYC_W(CW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus),
      .busy (busy)
   );

   initial forever #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   int unsigned  edge_n = 0;
   int           say_n = 0, ind_n = 0, enq_n = 0;
   int           say_edge = 0;
   logic [W-1:0] last_va, last_vb;
   job_s         exp_q[$];
   job_s         say_q[$];
   int           lat_q[$];
   result_t      got_q[$];

   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
      logic [W-1:0] a, b, t;
      a = a_in;
      b = b_in;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Transfer monitor: records every handshake seen on a rising edge.
   always @(posedge CLK) begin
      edge_n++;
      if (nRST) begin
         if (bus.job_enq_ena && bus.job_enq_rdy) begin
            exp_q.push_back('{va: bus.job_enq_va, vb: bus.job_enq_vb, tag: bus.job_enq_tag});
            enq_n++;
         end
         if (bus.request_say_ena && bus.request_say_rdy) begin
            say_q.push_back('{va: bus.request_say_va, vb: bus.request_say_vb, tag: '0});
            last_va  = bus.request_say_va;
            last_vb  = bus.request_say_vb;
            say_edge = edge_n;
            say_n++;
         end
         if (bus.indication_gcd_ena && bus.indication_gcd_rdy) begin
            lat_q.push_back(edge_n - say_edge - 1);
            ind_n++;
         end
         if (bus.result_deq_ena && bus.result_deq_rdy) begin
            result_t r;
            r.v      = bus.result_deq_v;
            r.tag    = bus.result_deq_tag;
            r.cycles = bus.result_deq_cycles;
            got_q.push_back(r);
         end
      end
   end

   // Engine model: accepts one request, answers gcd after a random delay, holds ENA until taken.
   initial begin
      int           cnt;
      bit           eng_busy;
      int           seen_say, seen_ind;
      logic [W-1:0] val;
      bus.request_say_rdy    = 1'b0;
      bus.indication_gcd_ena = 1'b0;
      bus.indication_gcd_v   = '0;
      eng_busy = 0;
      seen_say = 0;
      seen_ind = 0;
      cnt      = 0;
      val      = '0;
      forever begin
         @(negedge CLK);
         if (!nRST) begin
            eng_busy               = 0;
            bus.indication_gcd_ena = 1'b0;
            bus.request_say_rdy    = 1'b1;
            seen_say               = say_n;
            seen_ind               = ind_n;
         end else if (ind_n != seen_ind) begin
            seen_ind               = ind_n;
            eng_busy               = 0;
            bus.indication_gcd_ena = 1'b0;
            bus.request_say_rdy    = 1'b1;
         end else if (say_n != seen_say) begin
            seen_say            = say_n;
            eng_busy            = 1;
            bus.request_say_rdy = 1'b0;
            cnt                 = $urandom_range(2, 6);
            val                 = gcd_ref(last_va, last_vb);
         end else if (eng_busy && !bus.indication_gcd_ena) begin
            cnt--;
            if (cnt == 0) begin
               bus.indication_gcd_ena = 1'b1;
               bus.indication_gcd_v   = val;
            end
         end else if (!eng_busy) begin
            bus.request_say_rdy = ($urandom_range(0, 3) != 0);
         end
      end
   end

   task automatic clear_model();
      exp_q.delete();
      say_q.delete();
      lat_q.delete();
      got_q.delete();
   endtask

   task automatic enq_job(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [TW-1:0] tag,
                          output bit ok);
      bus.job_enq_ena = 1'b1;
      bus.job_enq_va  = va;
      bus.job_enq_vb  = vb;
      bus.job_enq_tag = tag;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus.job_enq_rdy) begin
            ok = 1;
            @(negedge CLK);
            break;
         end
         @(negedge CLK);
      end
      bus.job_enq_ena = 1'b0;
   endtask

   task automatic wait_result(output result_t r, output bit ok);
      ok = 0;
      r  = '0;
      for (int i = 0; i < 300; i++) begin
         if (got_q.size() > 0) begin
            r  = got_q.pop_front();
            ok = 1;
            return;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      repeat (2) @(negedge CLK);
      tests++; if (bus.job_enq_rdy !== 1'b0) begin fails++; $display("FAIL reset_enq_rdy got %b exp 0", bus.job_enq_rdy); end
      tests++; if (bus.result_deq_ena !== 1'b0) begin fails++; $display("FAIL reset_res_ena got %b exp 0", bus.result_deq_ena); end
      tests++; if (bus.request_say_ena !== 1'b0) begin fails++; $display("FAIL reset_say_ena got %b exp 0", bus.request_say_ena); end
      tests++; if (bus.indication_gcd_rdy !== 1'b0) begin fails++; $display("FAIL reset_ind_rdy got %b exp 0", bus.indication_gcd_rdy); end
      tests++; if (bus.result_deq_v !== '0) begin fails++; $display("FAIL reset_res_v got %0d exp 0", bus.result_deq_v); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      nRST = 1'b1;
      @(negedge CLK);
      tests++; if (bus.job_enq_rdy !== 1'b1) begin fails++; $display("FAIL post_reset_enq_rdy got %b exp 1", bus.job_enq_rdy); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy got %b exp 0", busy); end
   endtask

   task automatic test_single();
      result_t r;
      bit      ok;
      int      s0;
      clear_model();
      bus.result_deq_rdy = 1'b1;
      s0 = say_n;
      enq_job(12, 18, 3, ok);
      wait_result(r, ok);
      tests++; if (!ok) begin fails++; $display("FAIL single_timeout got none exp result"); end
      tests++; if (r.v !== 6 || r.tag !== 3) begin fails++; $display("FAIL single_value got v=%0d tag=%0d exp v=6 tag=3", r.v, r.tag); end
      tests++; if (say_n - s0 != 1 || say_q.size() != 1) begin fails++; $display("FAIL single_say_count got %0d exp 1", say_n - s0); end
      else begin
         tests++; if (say_q[0].va !== 12 || say_q[0].vb !== 18) begin fails++; $display("FAIL single_say_data got %0d,%0d exp 12,18", say_q[0].va, say_q[0].vb); end
      end
      tests++;
      if (lat_q.size() != 1 || r.cycles == 0 || r.cycles !== CW'(lat_q[0])) begin
         fails++; $display("FAIL single_cycles got %0d exp nonzero issue-to-indication count", r.cycles);
      end
   endtask

   task automatic test_zero_pair();
      bit ok;
      int s0;
      clear_model();
      bus.result_deq_rdy = 1'b0;
      s0 = say_n;
      enq_job(0, 0, 1, ok);
      tests++; if (bus.result_deq_ena !== 1'b0) begin fails++; $display("FAIL zero_early got %b exp 0", bus.result_deq_ena); end
      @(negedge CLK);
      tests++;
      if (bus.result_deq_ena !== 1'b1 || bus.result_deq_v !== '0 || bus.result_deq_tag !== 1 || bus.result_deq_cycles !== '0) begin
         fails++; $display("FAIL zero_result got ena=%b v=%0d tag=%0d cyc=%0d exp 1,0,1,0", bus.result_deq_ena, bus.result_deq_v, bus.result_deq_tag, bus.result_deq_cycles);
      end
      bus.result_deq_rdy = 1'b1;
      @(negedge CLK);
      tests++; if (bus.result_deq_ena !== 1'b0) begin fails++; $display("FAIL zero_drain got %b exp 0", bus.result_deq_ena); end
      tests++; if (say_n != s0) begin fails++; $display("FAIL zero_no_say got %0d exp 0", say_n - s0); end
   endtask

   task automatic test_degenerate();
      logic [W-1:0] va_t [2];
      logic [W-1:0] vb_t [2];
      result_t      r;
      bit           ok;
      int           s0;
      va_t = '{0, 9};
      vb_t = '{7, 0};
      bus.result_deq_rdy = 1'b1;
      for (int k = 0; k < 2; k++) begin
         clear_model();
         s0 = say_n;
         enq_job(va_t[k], vb_t[k], TW'(5 + k), ok);
         wait_result(r, ok);
         tests++;
         if (!ok || r.v !== gcd_ref(va_t[k], vb_t[k]) || r.tag !== TW'(5 + k) || say_n - s0 != 1) begin
            fails++; $display("FAIL degenerate_%0d got v=%0d tag=%0d says=%0d exp v=%0d tag=%0d says=1", k, r.v, r.tag, say_n - s0, gcd_ref(va_t[k], vb_t[k]), 5 + k);
         end
      end
   endtask

   task automatic test_queue_full();
      logic [W-1:0]  v_t [4];
      logic [TW-1:0] t_t [4];
      result_t       r;
      bit            ok;
      int            e0;
      v_t = '{0, 2, 5, 4};
      t_t = '{8, 9, 10, 11};
      clear_model();
      bus.result_deq_rdy = 1'b0;
      enq_job(0, 0, 8, ok);
      repeat (2) @(negedge CLK);
      e0 = enq_n;
      enq_job(10, 4, 9, ok);
      enq_job(15, 5, 10, ok);
      tests++; if (bus.job_enq_rdy !== 1'b0) begin fails++; $display("FAIL full_rdy got %b exp 0", bus.job_enq_rdy); end
      bus.job_enq_ena = 1'b1;
      bus.job_enq_va  = 8;
      bus.job_enq_vb  = 12;
      bus.job_enq_tag = 11;
      repeat (5) @(negedge CLK);
      tests++; if (enq_n - e0 != 2) begin fails++; $display("FAIL full_refuse got %0d accepts exp 2", enq_n - e0); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL full_busy got %b exp 1", busy); end
      bus.result_deq_rdy = 1'b1;
      enq_job(8, 12, 11, ok);
      for (int k = 0; k < 4; k++) begin
         wait_result(r, ok);
         tests++;
         if (!ok || r.v !== v_t[k] || r.tag !== t_t[k]) begin
            fails++; $display("FAIL full_order_%0d got v=%0d tag=%0d exp v=%0d tag=%0d", k, r.v, r.tag, v_t[k], t_t[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      result_t r, snap;
      bit      ok;
      int      s0;
      clear_model();
      bus.result_deq_rdy = 1'b0;
      enq_job(20, 8, 12, ok);
      for (int i = 0; i < 300 && !bus.result_deq_ena; i++) @(negedge CLK);
      snap.v      = bus.result_deq_v;
      snap.tag    = bus.result_deq_tag;
      snap.cycles = bus.result_deq_cycles;
      tests++; if (snap.v !== 4 || snap.tag !== 12) begin fails++; $display("FAIL bp_first got v=%0d tag=%0d exp v=4 tag=12", snap.v, snap.tag); end
      enq_job(30, 12, 13, ok);
      s0 = say_n;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         tests++;
         if (bus.result_deq_ena !== 1'b1 || bus.result_deq_v !== snap.v || bus.result_deq_tag !== snap.tag || bus.result_deq_cycles !== snap.cycles) begin
            fails++; $display("FAIL bp_stable_%0d got v=%0d tag=%0d exp v=%0d tag=%0d", i, bus.result_deq_v, bus.result_deq_tag, snap.v, snap.tag);
         end
      end
      tests++; if (say_n != s0) begin fails++; $display("FAIL bp_no_say got %0d exp 0", say_n - s0); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy got %b exp 1", busy); end
      bus.result_deq_rdy = 1'b1;
      wait_result(r, ok);
      wait_result(r, ok);
      tests++; if (!ok || r.v !== 6 || r.tag !== 13) begin fails++; $display("FAIL bp_second got v=%0d tag=%0d exp v=6 tag=13", r.v, r.tag); end
   endtask

   task automatic test_reset_mid_wait();
      result_t r;
      bit      ok;
      int      s0;
      clear_model();
      bus.result_deq_rdy = 1'b1;
      s0 = say_n;
      enq_job(100, 75, 14, ok);
      for (int i = 0; i < 200 && say_n == s0; i++) @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b0;
      repeat (2) @(negedge CLK);
      tests++;
      if (bus.request_say_ena !== 1'b0 || bus.indication_gcd_rdy !== 1'b0 || bus.result_deq_ena !== 1'b0 || bus.job_enq_rdy !== 1'b0) begin
         fails++; $display("FAIL midreset_outputs got say=%b ind=%b res=%b enq=%b exp all 0", bus.request_say_ena, bus.indication_gcd_rdy, bus.result_deq_ena, bus.job_enq_rdy);
      end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b exp 0", busy); end
      nRST = 1'b1;
      clear_model();
      @(negedge CLK);
      enq_job(21, 14, 15, ok);
      wait_result(r, ok);
      tests++; if (!ok || r.v !== 7 || r.tag !== 15) begin fails++; $display("FAIL midreset_after got v=%0d tag=%0d exp v=7 tag=15", r.v, r.tag); end
      repeat (10) @(negedge CLK);
      tests++; if (got_q.size() != 0) begin fails++; $display("FAIL midreset_stale got %0d extra results exp 0", got_q.size()); end
   endtask

   task automatic test_random();
      localparam int N = 24;
      result_t r;
      job_s    e, s;
      bit      ok;
      int      nz, s0, lat;
      logic [W-1:0] va, vb;
      clear_model();
      nz = 0;
      s0 = say_n;
      for (int k = 0; k < N; k++) begin
         case ($urandom_range(0, 5))
            0:       begin va = 0; vb = 0; end
            1:       begin va = 0; vb = $urandom_range(1, 500); end
            default: begin va = $urandom_range(1, 5000); vb = $urandom_range(1, 5000); end
         endcase
         if (!(va == 0 && vb == 0)) nz++;
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            bus.result_deq_rdy = ($urandom_range(0, 2) != 0);
            @(negedge CLK);
         end
         if (!bus.job_enq_rdy) bus.result_deq_rdy = 1'b1;
         enq_job(va, vb, TW'(k), ok);
      end
      bus.result_deq_rdy = 1'b1;
      for (int k = 0; k < N; k++) begin
         wait_result(r, ok);
         if (!ok || exp_q.size() == 0) begin
            tests++; fails++; $display("FAIL rand_timeout_%0d got none exp result", k);
            break;
         end
         e = exp_q.pop_front();
         tests++;
         if (r.v !== gcd_ref(e.va, e.vb) || r.tag !== e.tag) begin
            fails++; $display("FAIL rand_value_%0d got v=%0d tag=%0d exp v=%0d tag=%0d", k, r.v, r.tag, gcd_ref(e.va, e.vb), e.tag);
         end
         if (e.va == 0 && e.vb == 0) begin
            lat = 0;
         end else if (say_q.size() == 0 || lat_q.size() == 0) begin
            lat = -1;
         end else begin
            s   = say_q.pop_front();
            lat = lat_q.pop_front();
            tests++;
            if (s.va !== e.va || s.vb !== e.vb) begin
               fails++; $display("FAIL rand_say_%0d got %0d,%0d exp %0d,%0d", k, s.va, s.vb, e.va, e.vb);
            end
         end
         tests++;
         if (lat < 0 || r.cycles !== CW'(lat)) begin
            fails++; $display("FAIL rand_cycles_%0d got %0d exp %0d", k, r.cycles, lat);
         end
      end
      tests++; if (say_n - s0 != nz) begin fails++; $display("FAIL rand_say_count got %0d exp %0d", say_n - s0, nz); end
   endtask

   initial begin
      nRST               = 1'b0;
      bus.job_enq_ena    = 1'b0;
      bus.job_enq_va     = '0;
      bus.job_enq_vb     = '0;
      bus.job_enq_tag    = '0;
      bus.result_deq_rdy = 1'b0;
      test_reset();
      test_single();
      test_zero_pair();
      test_degenerate();
      test_queue_full();
      test_backpressure();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end

endmodule
